// File: rtl/mini_src_ctrl_pkg.sv
// Shared control encodings for the mini SRC datapath: bus/enable bit indices, opcodes, sequencer states.
// Shared by the sequencer, its decoder, the datapath and their benches.
package mini_src_ctrl_pkg;

  localparam int DP_PC   = 0;
  localparam int DP_IR   = 1;
  localparam int DP_Y    = 2;
  localparam int DP_MAR  = 3;
  localparam int DP_MDR  = 4;
  localparam int DP_Z    = 7;
  localparam int DP_ZHI  = 8;
  localparam int DP_ZLO  = 9;
  localparam int DP_HI   = 10;
  localparam int DP_LO   = 11;
  localparam int DP_READ = 12;

  // Opcodes 0-12 double as ALUopp bit indices.
  localparam int ALU_ADD = 0;
  localparam int ALU_SUB = 1;
  localparam int ALU_NEG = 2;
  localparam int ALU_MUL = 3;
  localparam int ALU_DIV = 4;
  localparam int ALU_AND = 5;
  localparam int ALU_OR  = 6;
  localparam int ALU_ROR = 7;
  localparam int ALU_ROL = 8;
  localparam int ALU_SLL = 9;
  localparam int ALU_SRA = 10;
  localparam int ALU_SRL = 11;
  localparam int ALU_NOT = 12;
  localparam int ALU_INC = 13;

  localparam logic [4:0] OP_HALT = 5'd31;

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_BINARY, C_UNARY, C_MULDIV, C_HALT, C_ILLEGAL
  } op_class_t;

  function automatic logic [15:0] onehot16(input logic [3:0] idx);
    return 16'(1) << idx;
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational IR decode into opcode class, ALU one-hot and register one-hots; zero latency.
// MULDIV_EN selects whether opcodes 3/4 are MUL/DIV or illegal.
module instr_decode
  import mini_src_ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output op_class_t   op_class,
  output logic [15:0] alu_oh,
  output logic [15:0] ra_oh,
  output logic [15:0] rb_oh,
  output logic [15:0] rc_oh
);

  logic [4:0] opcode;
  logic       unused_ir;

  assign opcode    = ir[31:27];
  assign ra_oh     = onehot16(ir[26:23]);
  assign rb_oh     = onehot16(ir[22:19]);
  assign rc_oh     = onehot16(ir[18:15]);
  assign unused_ir = ^ir[14:0];

  always_comb begin
    op_class = C_ILLEGAL;
    alu_oh   = '0;
    if (opcode == OP_HALT) begin
      op_class = C_HALT;
    end else begin
      case (int'(opcode))
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_ROR,
        ALU_ROL, ALU_SLL, ALU_SRA, ALU_SRL:  op_class = C_BINARY;
        ALU_NEG, ALU_NOT:                    op_class = C_UNARY;
`ifdef MULDIV_EN
        ALU_MUL, ALU_DIV:                    op_class = C_MULDIV;
`endif
        default:                             op_class = C_ILLEGAL;
      endcase
      if (op_class != C_ILLEGAL) alu_oh = onehot16(opcode[3:0]);
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute T-state sequencer; 6 cycles ALU, 7 MUL/DIV (MULDIV_EN), +1 per mem_ready=0 cycle in T1.
// Memory backpressure stalls only in T1; outputs are Moore (state + IR), never combinational on mem_ready.
module control_sequencer
  import mini_src_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        mem_ready,
  output logic [15:0] GRin,
  output logic [15:0] GRout,
  output logic [15:0] DPin,
  output logic [15:0] DPout,
  output logic [15:0] ALUopp,
  output logic        mem_rd,
  output logic        halted,
  output logic        illegal
);

  state_t      state_q, state_d;
  logic        illegal_q, illegal_d;
  op_class_t   op_class;
  logic [15:0] alu_oh, ra_oh, rb_oh, rc_oh;

  instr_decode u_decode (
    .ir       (IR),
    .op_class (op_class),
    .alu_oh   (alu_oh),
    .ra_oh    (ra_oh),
    .rb_oh    (rb_oh),
    .rc_oh    (rc_oh)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= S_RST;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    GRin      = '0;
    GRout     = '0;
    DPin      = '0;
    DPout     = '0;
    ALUopp    = '0;
    mem_rd    = 1'b0;
    halted    = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      S_RST: state_d = S_T0;
      S_T0: begin
        DPout[DP_PC]    = 1'b1;
        DPin[DP_MAR]    = 1'b1;
        DPin[DP_Z]      = 1'b1;
        ALUopp[ALU_INC] = 1'b1;
        state_d         = S_T1;
      end
      S_T1: begin
        DPout[DP_ZLO] = 1'b1;
        DPin[DP_PC]   = 1'b1;
        DPin[DP_READ] = 1'b1;
        DPin[DP_MDR]  = 1'b1;
        mem_rd        = 1'b1;
        if (mem_ready) state_d = S_T2;
      end
      S_T2: begin
        DPout[DP_MDR] = 1'b1;
        DPin[DP_IR]   = 1'b1;
        state_d       = S_T3;
      end
      S_T3: begin
        state_d = S_T4;
        case (op_class)
          C_BINARY: begin
            GRout      = rb_oh;
            DPin[DP_Y] = 1'b1;
          end
`ifdef MULDIV_EN
          C_MULDIV: begin
            GRout      = ra_oh;
            DPin[DP_Y] = 1'b1;
          end
`endif
          C_UNARY: ;
          default: begin
            state_d   = S_HALT;
            illegal_d = (op_class == C_ILLEGAL);
          end
        endcase
      end
      S_T4: begin
        DPin[DP_Z] = 1'b1;
        ALUopp     = alu_oh;
        GRout      = (op_class == C_BINARY) ? rc_oh : rb_oh;
        state_d    = S_T5;
      end
      S_T5: begin
        DPout[DP_ZLO] = 1'b1;
        GRin          = ra_oh;
        state_d       = S_T0;
`ifdef MULDIV_EN
        if (op_class == C_MULDIV) begin
          GRin        = '0;
          DPin[DP_LO] = 1'b1;
          state_d     = S_T6;
        end
`endif
      end
`ifdef MULDIV_EN
      S_T6: begin
        DPout[DP_ZHI] = 1'b1;
        DPin[DP_HI]   = 1'b1;
        state_d       = S_T0;
      end
`endif
      S_HALT: begin
        halted  = 1'b1;
        illegal = illegal_q;
      end
      default: state_d = S_RST;
    endcase
  end

endmodule
